// File: rtl/wb_write_port_arbiter.sv
// Register file write-port arbiter. It merges the in-order pipeline write-back with late
// results queued in a small skid FIFO, and it tracks destinations that are still pending.
module wb_write_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pipe_wr_en,
  input  logic [ADDR_W-1:0]             pipe_wr_addr,
  input  logic [DATA_W-1:0]             pipe_wr_data,
  input  logic                          late_valid,
  output logic                          late_ready,
  input  logic [ADDR_W-1:0]             late_addr,
  input  logic [DATA_W-1:0]             late_data,
  input  logic                          issue_en,
  input  logic [ADDR_W-1:0]             issue_addr,
  input  logic [ADDR_W-1:0]             rd_addr_1,
  input  logic [ADDR_W-1:0]             rd_addr_2,
  output logic                          rd_busy_1,
  output logic                          rd_busy_2,
  output logic                          stall_req,
  output logic                          reg_write_en,
  output logic [ADDR_W-1:0]             write_addr,
  output logic [DATA_W-1:0]             write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam int NREG  = 1 << ADDR_W;

  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] fifo_addr_r;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] fifo_data_r;
  logic [PTR_W-1:0]                  wr_ptr_r;
  logic [PTR_W-1:0]                  rd_ptr_r;
  logic [CNT_W-1:0]                  count_r;
  logic [AGE_W-1:0]                  age_r;
  logic [NREG-1:0]                   pending_r;
  logic                              stall_req_r;
  logic                              reg_write_en_r;
  logic [ADDR_W-1:0]                 write_addr_r;
  logic [DATA_W-1:0]                 write_data_r;

  logic                              push_s;
  logic                              pop_s;
  logic [ADDR_W-1:0]                 head_addr_s;
  logic [DATA_W-1:0]                 head_data_s;
  logic [AGE_W-1:0]                  age_next_s;
  logic [NREG-1:0]                   clr_mask_s;
  logic [NREG-1:0]                   set_mask_s;
  logic [NREG-1:0]                   pending_next_s;

  // Handshake, pop selection, age and scoreboard next-state
  always_comb begin
    late_ready  = rst_n && (count_r < CNT_W'(FIFO_DEPTH));
    push_s      = late_valid && late_ready;
    pop_s       = !pipe_wr_en && (count_r != '0);
    head_addr_s = fifo_addr_r[rd_ptr_r];
    head_data_s = fifo_data_r[rd_ptr_r];
    if (pop_s || (count_r == '0)) begin
      age_next_s = '0;
    end else if (age_r < AGE_W'(STARVE_LIMIT)) begin
      age_next_s = age_r + AGE_W'(1);
    end else begin
      age_next_s = age_r;
    end
    // Set is ORed in after the clear so a same-cycle re-issue keeps the bit pending
    clr_mask_s     = pop_s ? (NREG'(1) << head_addr_s) : '0;
    set_mask_s     = (issue_en && (issue_addr != '0)) ? (NREG'(1) << issue_addr) : '0;
    pending_next_s = (pending_r & ~clr_mask_s) | set_mask_s;
  end

  // FIFO storage, pointers, occupancy, age, scoreboard and registered write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_addr_r    <= '0;
      fifo_data_r    <= '0;
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      age_r          <= '0;
      pending_r      <= '0;
      stall_req_r    <= 1'b0;
      reg_write_en_r <= 1'b0;
      write_addr_r   <= '0;
      write_data_r   <= '0;
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= late_addr;
        fifo_data_r[wr_ptr_r] <= late_data;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r     <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      age_r       <= age_next_s;
      pending_r   <= pending_next_s;
      stall_req_r <= (age_r == AGE_W'(STARVE_LIMIT)) && !pop_s;
      // Writes to register 0 are consumed but never enabled
      if (pipe_wr_en) begin
        reg_write_en_r <= (pipe_wr_addr != '0);
        write_addr_r   <= pipe_wr_addr;
        write_data_r   <= pipe_wr_data;
      end else if (pop_s) begin
        reg_write_en_r <= (head_addr_s != '0);
        write_addr_r   <= head_addr_s;
        write_data_r   <= head_data_s;
      end else begin
        reg_write_en_r <= 1'b0;
      end
    end
  end

  assign rd_busy_1    = (rd_addr_1 != '0) && pending_r[rd_addr_1];
  assign rd_busy_2    = (rd_addr_2 != '0) && pending_r[rd_addr_2];
  assign stall_req    = stall_req_r;
  assign reg_write_en = reg_write_en_r;
  assign write_addr   = write_addr_r;
  assign write_data   = write_data_r;
  assign fifo_count   = count_r;

endmodule

// File: tb/tb_wb_write_port_arbiter.sv
// Directed bench for wb_write_port_arbiter covering pipeline, late path, scoreboard, starvation and reset.
module tb_wb_write_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_wr_en;
  logic [4:0]  pipe_wr_addr;
  logic [31:0] pipe_wr_data;
  logic        late_valid;
  logic        late_ready;
  logic [4:0]  late_addr;
  logic [31:0] late_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [4:0]  rd_addr_1;
  logic [4:0]  rd_addr_2;
  logic        rd_busy_1;
  logic        rd_busy_2;
  logic        stall_req;
  logic        reg_write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [1:0]  fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  wb_write_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
    .late_valid(late_valid), .late_ready(late_ready), .late_addr(late_addr), .late_data(late_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
    .stall_req(stall_req), .reg_write_en(reg_write_en), .write_addr(write_addr),
    .write_data(write_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_wr_en = 1'b0; pipe_wr_addr = 5'd0; pipe_wr_data = 32'd0;
    late_valid = 1'b0; late_addr = 5'd0; late_data = 32'd0;
    issue_en = 1'b0; issue_addr = 5'd0;
  endtask

  task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    check_eq({tag, "_en"}, 64'(reg_write_en), 64'd1);
    check_eq({tag, "_addr"}, 64'(write_addr), 64'(a));
    check_eq({tag, "_data"}, 64'(write_data), 64'(d));
  endtask

  initial begin
    idle();
    rd_addr_1 = 5'd0; rd_addr_2 = 5'd0;
    rst_n = 1'b0;
    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      pipe_wr_en = 1'($urandom); pipe_wr_addr = 5'($urandom); pipe_wr_data = $urandom;
      late_valid = 1'b1; late_addr = 5'($urandom); late_data = $urandom;
      issue_en = 1'b1; issue_addr = 5'($urandom_range(1, 31));
      rd_addr_1 = issue_addr;
      step();
      check_eq("rst_wen", 64'(reg_write_en), 64'd0);
      check_eq("rst_waddr", 64'(write_addr), 64'd0);
      check_eq("rst_wdata", 64'(write_data), 64'd0);
      check_eq("rst_stall", 64'(stall_req), 64'd0);
      check_eq("rst_ready", 64'(late_ready), 64'd0);
      check_eq("rst_count", 64'(fifo_count), 64'd0);
      check_eq("rst_busy", 64'(rd_busy_1), 64'd0);
    end
    idle();
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready", 64'(late_ready), 64'd1);
    check_eq("rel_count", 64'(fifo_count), 64'd0);

    // Pipeline write, then pipeline write to register 0
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd5; pipe_wr_data = 32'hDEADBEEF;
    step();
    check_write("pipe5", 5'd5, 32'hDEADBEEF);
    pipe_wr_addr = 5'd0; pipe_wr_data = 32'h1;
    step();
    check_eq("pipe0_en", 64'(reg_write_en), 64'd0);
    idle();
    step();
    check_eq("idle_en", 64'(reg_write_en), 64'd0);

    // Late path with scoreboard
    issue_en = 1'b1; issue_addr = 5'd9;
    step();
    idle();
    rd_addr_1 = 5'd9; rd_addr_2 = 5'd0;
    #1;
    check_eq("busy9_issued", 64'(rd_busy_1), 64'd1);
    check_eq("busy0", 64'(rd_busy_2), 64'd0);
    late_valid = 1'b1; late_addr = 5'd9; late_data = 32'h1234;
    step();
    idle();
    #1;
    check_eq("late_count1", 64'(fifo_count), 64'd1);
    check_eq("busy9_queued", 64'(rd_busy_1), 64'd1);
    check_eq("late_noweyet", 64'(reg_write_en), 64'd0);
    step();
    check_write("late9", 5'd9, 32'h1234);
    check_eq("busy9_cleared", 64'(rd_busy_1), 64'd0);
    check_eq("late_count0", 64'(fifo_count), 64'd0);

    // Contention: pipeline held six cycles while three late results are offered
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd3; pipe_wr_data = 32'h33;
    late_valid = 1'b1; late_addr = 5'd10; late_data = 32'hA0;
    step();                                     // E1: push A
    check_eq("ct_count1", 64'(fifo_count), 64'd1);
    late_addr = 5'd11; late_data = 32'hB0;
    step();                                     // E2: push B
    check_eq("ct_count2", 64'(fifo_count), 64'd2);
    check_eq("ct_full_ready", 64'(late_ready), 64'd0);
    late_addr = 5'd12; late_data = 32'hC0;
    step();                                     // E3: C refused
    check_eq("ct_count_hold", 64'(fifo_count), 64'd2);
    check_write("ct_pipe", 5'd3, 32'h33);
    step();                                     // E4
    step();                                     // E5
    check_eq("ct_stall_early", 64'(stall_req), 64'd0);
    step();                                     // E6
    check_eq("ct_stall", 64'(stall_req), 64'd1);
    pipe_wr_en = 1'b0;
    step();                                     // E7: pop A
    check_write("drainA", 5'd10, 32'hA0);
    check_eq("ct_stall_drop", 64'(stall_req), 64'd0);
    step();                                     // E8: pop B, push C
    late_valid = 1'b0;
    check_write("drainB", 5'd11, 32'hB0);
    check_eq("ct_count_pp", 64'(fifo_count), 64'd1);
    step();                                     // E9: pop C
    check_write("drainC", 5'd12, 32'hC0);
    check_eq("ct_count_end", 64'(fifo_count), 64'd0);
    step();
    check_eq("ct_idle_en", 64'(reg_write_en), 64'd0);

    // Collision: re-issue 7 in the cycle its queued result pops
    idle();
    rd_addr_1 = 5'd7;
    issue_en = 1'b1; issue_addr = 5'd7;
    step();
    issue_en = 1'b0;
    late_valid = 1'b1; late_addr = 5'd7; late_data = 32'h77;
    step();
    late_valid = 1'b0;
    issue_en = 1'b1; issue_addr = 5'd7;
    step();
    issue_en = 1'b0;
    #1;
    check_write("col7", 5'd7, 32'h77);
    check_eq("col_busy7", 64'(rd_busy_1), 64'd1);
    late_valid = 1'b1; late_addr = 5'd7; late_data = 32'h78;
    step();
    late_valid = 1'b0;
    step();
    check_write("col7b", 5'd7, 32'h78);
    check_eq("col_busy7_clr", 64'(rd_busy_1), 64'd0);

    // Late write to register 0 is consumed without a write
    late_valid = 1'b1; late_addr = 5'd0; late_data = 32'h55;
    step();
    late_valid = 1'b0;
    step();
    check_eq("late0_en", 64'(reg_write_en), 64'd0);
    check_eq("late0_count", 64'(fifo_count), 64'd0);

    // Mid-operation reset with two queued entries and three pending bits
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd1; pipe_wr_data = 32'h1;
    issue_en = 1'b1; issue_addr = 5'd20;
    late_valid = 1'b1; late_addr = 5'd20; late_data = 32'h20;
    step();
    issue_addr = 5'd21; late_addr = 5'd21; late_data = 32'h21;
    step();
    issue_addr = 5'd22; late_valid = 1'b0;
    step();
    idle();
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd1; pipe_wr_data = 32'h1;
    rd_addr_1 = 5'd20; rd_addr_2 = 5'd22;
    #1;
    check_eq("mr_count", 64'(fifo_count), 64'd2);
    check_eq("mr_busy20", 64'(rd_busy_1), 64'd1);
    check_eq("mr_busy22", 64'(rd_busy_2), 64'd1);
    rst_n = 1'b0;
    idle();
    step();
    check_eq("mr_wen", 64'(reg_write_en), 64'd0);
    check_eq("mr_count0", 64'(fifo_count), 64'd0);
    check_eq("mr_busy20_clr", 64'(rd_busy_1), 64'd0);
    check_eq("mr_busy22_clr", 64'(rd_busy_2), 64'd0);
    rst_n = 1'b1;
    rd_addr_1 = 5'd21;
    #1;
    check_eq("mr_busy21_clr", 64'(rd_busy_1), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("mr_nowrite", 64'(reg_write_en), 64'd0);
    end
    check_eq("mr_ready", 64'(late_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
